// File: rtl/io_output_serializer.sv
// Start/stop framed serializer driving one output pad bit.
// Bit period is div+1 clocks, captured with the word at acceptance.
module io_output_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DIV_WIDTH-1:0]  div,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [0:0]            iopad_outpad,
  output logic                  busy,
  output logic                  frame_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int IDXW =
    (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDXW-1:0] LAST_IDX =
    IDXW'(DATA_WIDTH - 1);

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DIV_WIDTH-1:0]  div_q, div_d;
  logic [DIV_WIDTH-1:0]  timer_q, timer_d;
  logic [IDXW-1:0]       idx_q, idx_d;
  logic                  pad_q, pad_d;
  logic                  done_q, done_d;

  logic accept;
  logic bit_end;
  logic last_bit;

  assign accept   = in_valid && (state_q == IDLE);
  assign bit_end  = (timer_q == div_q);
  assign last_bit = (idx_q == LAST_IDX);

  // State and datapath registers; reset wins over any handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      div_q   <= '0;
      timer_q <= '0;
      idx_q   <= '0;
      pad_q   <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      div_q   <= div_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      pad_q   <= pad_d;
      done_q  <= done_d;
    end
  end

  // Next-state: each phase advances when its bit period expires
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (accept) state_d = START;
      START: if (bit_end) state_d = DATA;
      DATA:  if (bit_end && last_bit) state_d = STOP;
      STOP:  if (bit_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: timer runs 0..div, pad is precomputed
  always_comb begin
    shift_d = shift_q;
    div_d   = div_q;
    idx_d   = idx_q;
    pad_d   = pad_q;
    done_d  = 1'b0;
    if (state_q == IDLE || bit_end) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + DIV_WIDTH'(1);
    end
    unique case (state_q)
      IDLE: begin
        pad_d = 1'b1;
        if (accept) begin
          shift_d = in_data;
          div_d   = div;
          idx_d   = '0;
          pad_d   = 1'b0;
        end
      end
      START: begin
        if (bit_end) pad_d = shift_q[0];
      end
      DATA: begin
        if (bit_end) begin
          if (last_bit) begin
            pad_d = 1'b1;
          end else begin
            shift_d = shift_q >> 1;
            idx_d   = idx_q + IDXW'(1);
            pad_d   = shift_d[0];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          pad_d  = 1'b1;
          done_d = 1'b1;
          idx_d  = '0;
        end
      end
      default: pad_d = 1'b1;
    endcase
  end

  // Outputs: handshake and status decoded from state
  always_comb begin
    in_ready        = (state_q == IDLE);
    busy            = (state_q != IDLE);
    frame_done      = done_q;
    iopad_outpad[0] = pad_q;
  end

endmodule

// File: tb/tb_io_output_serializer.sv
// Directed bench for io_output_serializer (DATA_WIDTH=8, DIV_WIDTH=8).
// Pad/busy/done checked every cycle of each frame against expected bits.
module tb_io_output_serializer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] div;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [0:0] iopad_outpad;
  logic       busy;
  logic       frame_done;

  int pass_cnt = 0;
  int total    = 0;

  io_output_serializer #(
    .DATA_WIDTH(8),
    .DIV_WIDTH (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .div         (div),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .iopad_outpad(iopad_outpad),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog pass=%0d total=%0d", pass_cnt, total);
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {in_ready, busy, frame_done, pad}
  task automatic chk(input string tag, input logic [3:0] exp);
    logic [3:0] obs;
    obs = {in_ready, busy, frame_done, iopad_outpad[0]};
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  // Accept word d with period dv+1, then drive the given inputs
  // during the frame and check every cycle up to the first IDLE.
  task automatic frame(input string tag,
                       input logic [7:0] d,
                       input logic [7:0] dv,
                       input logic       keep_valid,
                       input logic [7:0] nd,
                       input logic [7:0] ndv);
    logic b;
    in_data  = d;
    div      = dv;
    in_valid = 1'b1;
    tick();
    in_valid = keep_valid;
    in_data  = nd;
    div      = ndv;
    for (int k = 0; k < 10; k++) begin
      if (k == 0)      b = 1'b0;
      else if (k == 9) b = 1'b1;
      else             b = d[k-1];
      for (int c = 0; c <= int'(dv); c++) begin
        chk(tag, {1'b0, 1'b1, 1'b0, b});
        tick();
      end
    end
    chk({tag, "_done"}, 4'b1011);
  endtask

  initial begin
    reset    = 1'b1;
    div      = 8'd0;
    in_data  = 8'd0;
    in_valid = 1'b0;
    tick();
    tick();
    chk("reset", 4'b1001);
    reset = 1'b0;
    tick();
    chk("idle", 4'b1001);

    // 0xA5, div=0: pad 0,1,0,1,0,0,1,0,1,1
    frame("a5", 8'hA5, 8'd0, 1'b0, 8'h00, 8'd0);
    tick();
    chk("a5_pulse", 4'b1001);

    // 0x01, div=3: 4 cycles per bit, 40 busy cycles
    frame("d3", 8'h01, 8'd3, 1'b0, 8'h00, 8'd3);
    tick();
    chk("d3_pulse", 4'b1001);

    // back-to-back with in_valid held: one idle cycle between
    frame("b55", 8'h55, 8'd0, 1'b1, 8'hAA, 8'd0);
    frame("bAA", 8'hAA, 8'd0, 1'b0, 8'h00, 8'd0);
    tick();
    chk("bAA_pulse", 4'b1001);

    // inputs changed mid-frame must not disturb it
    frame("chg", 8'h3C, 8'd0, 1'b0, 8'hC3, 8'd5);
    tick();
    chk("chg_pulse", 4'b1001);

    // reset during 4th data bit (div=1, bit3 of 0xF7 is 0)
    in_data  = 8'hF7;
    div      = 8'd1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (8) tick();
    chk("rst_bit3", 4'b0100);
    reset    = 1'b1;
    in_valid = 1'b1;
    tick();
    chk("rst_abort", 4'b1001);
    tick();
    chk("rst_hold", 4'b1001);
    reset    = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rst_no_done", 4'b1001);
    end

    // div=255: 256 cycles per bit
    frame("d255", 8'h81, 8'd255, 1'b0, 8'h00, 8'd0);
    tick();
    chk("d255_pulse", 4'b1001);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
